// File: rtl/issue_scoreboard_pkg.sv
// Shared encodings for the issue scoreboard: bypass selects, result latency
// classes and the stage index at which each class becomes forwardable.
package issue_scoreboard_pkg;

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_M1S  = 2'd1;
  localparam logic [1:0] FWD_M2S  = 2'd2;
  localparam logic [1:0] FWD_WB   = 2'd3;

  localparam logic [1:0] LAT_ALU  = 2'd0;
  localparam logic [1:0] LAT_LOAD = 2'd1;
  localparam logic [1:0] LAT_LATE = 2'd2;

  localparam logic [1:0] RDY_ALU  = 2'd1;
  localparam logic [1:0] RDY_LOAD = 2'd2;
  localparam logic [1:0] RDY_LATE = 2'd3;

  localparam int NUM_SLOTS = 4;

  // The reserved class 3 is folded into LATE.
  function automatic logic [1:0] rdy_of(input logic [1:0] lat);
    case (lat)
      LAT_ALU:  return RDY_ALU;
      LAT_LOAD: return RDY_LOAD;
      default:  return RDY_LATE;
    endcase
  endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode-stage <-> scoreboard interface. The decode side is the master.
interface issue_scoreboard_if #(
  parameter int RD_W   = 5,
  parameter int STAT_W = 32
);
  // Handshake: ds_valid is the offer from DS; ds_issue is the acceptance.
  // An instruction moves to ES only in a cycle where both are high, and DS
  // must hold its fields stable while ds_valid=1 and ds_issue=0.
  logic              ds_valid;
  logic [RD_W-1:0]   ds_rs1;
  logic [RD_W-1:0]   ds_rs2;
  logic [RD_W-1:0]   ds_rd;
  logic              ds_reg_write;
  logic [1:0]        ds_lat;
  logic              pipe_adv;
  logic              flush;
  logic              ds_issue;
  logic              ds_stall;
  logic [1:0]        fwd1;
  logic [1:0]        fwd2;
  logic [STAT_W-1:0] stall_cnt;

  modport master (
    output ds_valid, ds_rs1, ds_rs2, ds_rd, ds_reg_write, ds_lat, pipe_adv, flush,
    input  ds_issue, ds_stall, fwd1, fwd2, stall_cnt
  );

  modport slave (
    input  ds_valid, ds_rs1, ds_rs2, ds_rd, ds_reg_write, ds_lat, pipe_adv, flush,
    output ds_issue, ds_stall, fwd1, fwd2, stall_cnt
  );
endinterface

// File: rtl/issue_scoreboard_sb_lookup.sv
// Per-source priority match against the in-flight slots: youngest valid
// producer of rs decides between a hazard and a bypass select.
module sb_lookup
  import issue_scoreboard_pkg::*;
#(
  parameter int RD_W = 5
) (
  input  logic                      en,
  input  logic [RD_W-1:0]           rs,
  input  logic [NUM_SLOTS-1:0]      slot_v,
  input  logic [NUM_SLOTS*RD_W-1:0] slot_rd,
  input  logic [NUM_SLOTS*2-1:0]    slot_rdy,
  output logic                      hazard,
  output logic [1:0]                fwd
);

  // Scan oldest to youngest so the youngest match overwrites the result.
  always_comb begin
    hazard = 1'b0;
    fwd    = FWD_NONE;
    if (en && (rs != '0)) begin
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
        if (slot_v[i] && (slot_rd[i*RD_W +: RD_W] == rs)) begin
          if (2'(i) < slot_rdy[2*i +: 2]) begin
            hazard = 1'b1;
            fwd    = FWD_NONE;
          end else begin
            hazard = 1'b0;
            fwd    = 2'(i);
          end
        end
      end
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Dual-source issue interlock and bypass-select scheduler for ES/M1S/M2S/WS.
// Optional stall statistics counter: define SCOREBOARD_STATS_EN.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int RD_W   = 5,
  parameter int STAT_W = 32
) (
  input logic          clk,
  input logic          resetn,
  issue_scoreboard_if.slave sb
);

  logic [NUM_SLOTS-1:0]      slot_v;
  logic [RD_W-1:0]           slot_rd  [NUM_SLOTS];
  logic [1:0]                slot_rdy [NUM_SLOTS];
  logic [NUM_SLOTS*RD_W-1:0] rd_flat;
  logic [NUM_SLOTS*2-1:0]    rdy_flat;

  logic       lookup_en;
  logic       hazard1;
  logic       hazard2;
  logic [1:0] fwd1_raw;
  logic [1:0] fwd2_raw;
  logic       issue;
  logic       stall;
  logic       new_v;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_flat
    assign rd_flat[g*RD_W +: RD_W] = slot_rd[g];
    assign rdy_flat[2*g +: 2]      = slot_rdy[g];
  end

  // Outputs are forced low while reset is held, independent of DS inputs.
  assign lookup_en = resetn & sb.ds_valid;

  sb_lookup #(.RD_W(RD_W)) u_lookup_rs1 (
    .en       (lookup_en),
    .rs       (sb.ds_rs1),
    .slot_v   (slot_v),
    .slot_rd  (rd_flat),
    .slot_rdy (rdy_flat),
    .hazard   (hazard1),
    .fwd      (fwd1_raw)
  );

  sb_lookup #(.RD_W(RD_W)) u_lookup_rs2 (
    .en       (lookup_en),
    .rs       (sb.ds_rs2),
    .slot_v   (slot_v),
    .slot_rd  (rd_flat),
    .slot_rdy (rdy_flat),
    .hazard   (hazard2),
    .fwd      (fwd2_raw)
  );

  assign issue = lookup_en & sb.pipe_adv & ~sb.flush & ~hazard1 & ~hazard2;
  assign stall = lookup_en & ~issue;
  assign new_v = issue & sb.ds_reg_write & (sb.ds_rd != '0);

  assign sb.ds_issue = issue;
  assign sb.ds_stall = stall;
  assign sb.fwd1     = fwd1_raw;
  assign sb.fwd2     = fwd2_raw;

  // Flush kills everything; otherwise the slots shift with the back end and a
  // bubble enters ES whenever nothing issues.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_v <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_rd[i]  <= '0;
        slot_rdy[i] <= '0;
      end
    end else if (sb.flush) begin
      slot_v <= '0;
    end else if (sb.pipe_adv) begin
      slot_v <= {slot_v[NUM_SLOTS-2:0], new_v};
      for (int i = NUM_SLOTS - 1; i > 0; i--) begin
        slot_rd[i]  <= slot_rd[i-1];
        slot_rdy[i] <= slot_rdy[i-1];
      end
      slot_rd[0]  <= sb.ds_rd;
      slot_rdy[0] <= rdy_of(sb.ds_lat);
    end
  end

`ifdef SCOREBOARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign sb.stall_cnt = stall_cnt_q;
`else
  assign sb.stall_cnt = {STAT_W{1'b0}};
`endif

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Dual-pipe issue interlock and forwarding-select scheduler for the ES/M1S/M2S/WS back end.
- Tracks in-flight destination registers in a 4-slot shift pipeline that mirrors ES, M1S, M2S and WS.
- Decides each cycle whether the DS instruction may issue. Emits the bypass selects (none/M1S/M2S/WB) that DS uses for rs1/rs2.
- Sits between the decode stage and the operand-bypass muxes. Replaces per-stage valid/rd comparison glue with one registered structure.

Parameters:
- RD_W, 5, register index width
- STAT_W, 32, width of the stall statistics counter (optional feature only)

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- ds_valid  in  1  DS holds a valid instruction
- ds_rs1  in  RD_W  source register 1
- ds_rs2  in  RD_W  source register 2
- ds_rd  in  RD_W  destination register
- ds_reg_write  in  1  DS instruction writes the register file
- ds_lat  in  2  result class: 0 ALU, 1 LOAD, 2 LATE (HI/LO, CP0, ready only at WS)
- pipe_adv  in  1  back end advances one stage this cycle
- flush  in  1  exception/ERET flush; kills all in-flight entries
- ds_issue  out  1  DS instruction moves into ES this cycle
- ds_stall  out  1  ds_valid & ~ds_issue
- fwd1  out  2  bypass select for rs1: 0 none/RF, 1 M1S, 2 M2S, 3 WB
- fwd2  out  2  bypass select for rs2, same encoding
- stall_cnt  out  STAT_W  cycles with ds_stall=1 (only with SCOREBOARD_STATS_EN)

Behaviour:
- Slot state
  - Four registered slots S[0]=ES, S[1]=M1S, S[2]=M2S, S[3]=WS.
  - Each slot holds {v, rd, rdy}, where rdy is the stage index at which the value becomes forwardable: ALU=1, LOAD=2, LATE=3.
- Reset (resetn=0, asynchronous): all slot v=0 and stall_cnt=0. Therefore ds_issue=0, ds_stall=0, fwd1=fwd2=0.
- Hazard lookup (combinational from registered slots, per source rs):
  - If rs==0, there is no match and fwd=0.
  - Otherwise find the youngest valid slot i with S[i].rd==rs, searching ES first, then M1S, M2S, WS.
  - No match: fwd=0, no hazard.
  - Match with i<S[i].rdy: hazard, fwd=0.
  - Match with i>=S[i].rdy: fwd=i, where i=1→1, 2→2, 3→3.
  - A match in ES is always a hazard, because rdy>=1.
  - Sources are only checked when ds_valid=1; otherwise fwd1=fwd2=0.
- Issue rule: ds_issue = ds_valid & pipe_adv & ~flush & ~hazard1 & ~hazard2.
- Slot update, in priority order:
  1. flush=1: all v<=0 next cycle. Takes priority over pipe_adv and issue.
  2. pipe_adv=1: S[3]<=S[2], S[2]<=S[1], S[1]<=S[0]. S[0] <= {ds_issue & ds_reg_write & (ds_rd!=0), ds_rd, rdy(ds_lat)}; a bubble is inserted when nothing issues. The old S[3] is retired.
  3. pipe_adv=0: all slots hold.
- Latency: a stall clears in the first cycle after the producer reaches its rdy stage.
  - ALU→consumer back-to-back: 1 stall cycle.
  - LOAD→use: 2 stall cycles.
  - Stall count assumes pipe_adv=1 throughout.
- ds_lat=3 (reserved) is treated as LATE.
- Simultaneous events:
  - Flush concurrent with a would-be issue: no issue.
  - rd of the issuing instruction equal to its own rs: the lookup uses pre-issue slots, so no self-hazard.

Optional Feature:
- Macro SCOREBOARD_STATS_EN.
- Defined: stall_cnt increments (wrapping) every cycle with ds_stall=1. It is cleared only by reset.
- Undefined: stall_cnt is driven constant 0 and no counter register is built.

Decomposition:
- Shared package/header (mycpu.h) holds:
  - FWD_NONE=0, FWD_M1S=1, FWD_M2S=2, FWD_WB=3
  - LAT_ALU=0, LAT_LOAD=1, LAT_LATE=2
  - RDY_* stage constants
- One sub-module, sb_lookup: the per-source priority match, instantiated twice (rs1, rs2). It takes the slot vectors and rs, and returns {hazard, fwd}.

Test Plan:
- Reset then idle: resetn low mid-run with slots valid → all outputs 0 immediately; after release, ds_valid=0 gives ds_issue=0, fwd=00.
- ALU chain: issue addu $3 (ALU), then addu $4,$3,$3 with pipe_adv=1 → 1 stall cycle, then ds_issue=1 with fwd1=fwd2=1 (M1S).
- Load-use: lw $5, then addu $6,$5,$0 → 2 stall cycles, then issue with fwd1=2 (M2S), fwd2=0.
- Youngest wins: ALU writes $7, bubble, ALU writes $7 again, then consumer reads $7 → stalls 1 cycle, then fwd1=1 (from the younger producer), not 2.
- Hold and flush: lw $8 in ES, pipe_adv=0 for 3 cycles → consumer stays stalled and slots hold. Then flush=1 → next cycle all slots clear, consumer of $8 issues with fwd1=0. With SCOREBOARD_STATS_EN, stall_cnt=4.
- r0 and no-write: producer with rd=0 or reg_write=0, consumer reads $0 / that rd → no stall, fwd=0.
